// File: rtl/quadratic_pkg.sv
// Shared defaults for the quadratic datapath: ax2_bx computes A*x^2 + B*x,
// and add_c downstream adds C.
package quadratic_pkg;
  localparam int          DEF_WIDTH = 16;
  localparam logic [15:0] DEF_A     = 16'd101;
  localparam logic [15:0] DEF_B     = 16'd59;
  localparam logic [15:0] DEF_C     = 16'd7;
endpackage

// File: rtl/quad_pipe_stage.sv
// One valid/data pipeline register. It loads only on adv, so a stalled
// stage holds its contents.
module quad_pipe_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          vld_in,
  input  logic [DW-1:0] d_in,
  output logic          vld,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (adv) begin
      vld <= vld_in;
      q   <= d_in;
    end
  end
endmodule

// File: rtl/ax2_bx.sv
// y = A*x^2 + B*x in Horner form, (A*x + B)*x, over two elastic stages.
// o_ovf flags an exact result of 2^WIDTH or more.
module ax2_bx
  import quadratic_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] A     = WIDTH'(DEF_A),
  parameter logic [WIDTH-1:0] B     = WIDTH'(DEF_B)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_x,
  input  logic             i_valid_in,
  output logic             i_ready_out,
  output logic [WIDTH-1:0] o_y,
  output logic             o_ovf,
  output logic             o_valid_out,
  input  logic             o_ready_in
);
  localparam int W2  = 2 * WIDTH;
  localparam int S1W = W2 + 1;

  logic             s1_valid, adv_o, adv_1;
  logic [S1W-1:0]   s1_d, s1_q;
  logic [WIDTH:0]   o_d, o_q;
  logic [W2-1:0]    ax_b, tx;
  logic [WIDTH-1:0] s1_t, s1_x;
  logic             s1_c;

  assign adv_o       = !o_valid_out || o_ready_in;
  assign adv_1       = !s1_valid || adv_o;
  assign i_ready_out = rst && adv_1;

  // A*x + B fits in 2*WIDTH bits; anything above bit WIDTH-1 is the S1 carry.
  assign ax_b = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, i_x} + {{WIDTH{1'b0}}, B};
  assign s1_d = {|ax_b[W2-1:WIDTH], ax_b[WIDTH-1:0], i_x};

  quad_pipe_stage #(.DW(S1W)) u_s1 (
    .clk(clk), .rst(rst), .adv(adv_1), .vld_in(i_valid_in),
    .d_in(s1_d), .vld(s1_valid), .q(s1_q)
  );

  assign {s1_c, s1_t, s1_x} = s1_q;

  // A carry out of S1 with x >= 1 already implies the exact result overflows.
  assign tx  = {{WIDTH{1'b0}}, s1_t} * {{WIDTH{1'b0}}, s1_x};
  assign o_d = {s1_c || (|tx[W2-1:WIDTH]), tx[WIDTH-1:0]};

  quad_pipe_stage #(.DW(WIDTH + 1)) u_out (
    .clk(clk), .rst(rst), .adv(adv_o), .vld_in(s1_valid),
    .d_in(o_d), .vld(o_valid_out), .q(o_q)
  );

  assign {o_ovf, o_y} = o_q;
endmodule

// File: doc/ax2_bx.md
AX2_BX -- requirements
Module: ax2_bx

Interface
REQ-001 Parameter WIDTH, default 16: data width of x and y.
REQ-002 Parameter A, default 16'd101: quadratic coefficient, WIDTH bits.
REQ-003 Parameter B, default 16'd59: linear coefficient, WIDTH bits.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge).
REQ-006 i_x  input  WIDTH  operand x.
REQ-007 i_valid_in  input  1  i_x valid this cycle.
REQ-008 i_ready_out  output  1  block accepts i_x this cycle.
REQ-009 o_y  output  WIDTH  A*x^2 + B*x, truncated to WIDTH bits; feeds the add-C stage's i_x.
REQ-010 o_ovf  output  1  exact result was at least 2^WIDTH; qualified by o_valid_out.
REQ-011 o_valid_out  output  1  o_y/o_ovf valid.
REQ-012 o_ready_in  input  1  downstream accepts o_y this cycle.

Function
REQ-013 A transfer SHALL occur on a port only in a cycle where valid and ready are both 1.
REQ-014 Computation SHALL use Horner form in two registered stages: S1 holds t = (A*x + B) mod 2^WIDTH plus x; output stage holds o_y = (t*x) mod 2^WIDTH.
REQ-015 o_ovf SHALL be 1 iff A*x^2 + B*x, computed at full precision, is at least 2^WIDTH; equivalently, S1 carry-out OR high half of t*x non-zero.
REQ-016 Latency: input accepted at edge k -> o_valid_out=1 with its result after edge k+1, with no stall.
REQ-017 Throughput: one result per cycle while o_ready_in=1.
REQ-018 Output advance: adv_o = !o_valid_out | o_ready_in. S1 advance: adv_1 = !s1_valid | adv_o.
REQ-019 i_ready_out SHALL equal adv_1, combinationally; it SHALL NOT depend on i_valid_in.
REQ-020 On adv_o, the output stage SHALL load from S1; o_valid_out becomes s1_valid.
REQ-021 On adv_1, S1 SHALL load i_x; s1_valid becomes i_valid_in.
REQ-022 While o_valid_out=1 and o_ready_in=0, o_y, o_ovf and o_valid_out SHALL hold stable.
REQ-023 With both stages full and o_ready_in=0: i_ready_out=0, and no data is lost or duplicated.
REQ-024 Simultaneous output drain and input accept in one cycle SHALL be lossless; the block SHALL hold at most 2 items in flight.
REQ-025 Results SHALL leave in acceptance order.
REQ-026 All arithmetic SHALL be unsigned. Intermediate products SHALL be 2*WIDTH bits; only the low WIDTH bits are stored.
REQ-027 x=0 SHALL give o_y=0, o_ovf=0.

Reset
REQ-028 While rst=0 at a clk edge: s1_valid=0, o_valid_out=0, o_y=0, o_ovf=0, S1 data=0.
REQ-029 During reset, i_ready_out SHALL be 0; it SHALL be 1 in the first cycle after rst returns to 1.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight items; no output SHALL appear for them after reset.

Structure
REQ-031 Shared package quadratic_pkg SHALL hold the WIDTH, A, B and C default constants, used by this block and add_c.
REQ-032 One sub-module, quad_pipe_stage (a valid/data register with an advance enable), SHALL be instantiated for S1 and for the output stage.
REQ-033 No other sub-modules; multipliers are inferred.

Verification
REQ-034 x=2, o_ready_in=1 -> o_y=522, o_ovf=0, 2 cycles after accept.
REQ-035 Back-to-back x=0,1,10 with o_ready_in=1 -> o_y=0,160,10690 on consecutive cycles, in order.
REQ-036 x=100 -> o_y=32860 (1015900 mod 65536), o_ovf=1.
REQ-037 Stall test: accept 2 items, hold o_ready_in=0 for 5 cycles -> i_ready_out=0, o_y stable. Release -> both results delivered, none lost.
REQ-038 Random valid/ready over 1000 x values, checked against a reference model of (A*x^2+B*x) mod 2^16 plus ovf -> exact match, in order.
REQ-039 rst=0 with 2 items in flight -> o_valid_out=0 next cycle, and no stale output after rst returns to 1.
